baby_ram_arbiter: RTL and testbench
===================================

Name: baby_ram_arbiter

Overview:
Shares the Manchester Baby's single 32-word x 32-bit store between the Baby core and a host load/dump port.
- Owns the core's run enable: stops the core, drains its in-flight access, then serves host reads and writes.
- Resumes the core when the host releases.
- Sits between the core wrapper's ram_* pins and the physical RAM; also gives the host a boot-time program-load window.

Parameters:
ADDR_W, 5, RAM word-address width (32 words)
DATA_W, 32, RAM word width
DRAIN_CYCLES, 2, cycles the core is frozen with RAM writes blocked before host access is granted; legal range 1..15

Ports:
clock  in  1  single system clock, rising edge
reset_i  in  1  asynchronous, active-low reset
cpu_addr_i  in  ADDR_W  core RAM address
cpu_data_i  in  DATA_W  core write data
cpu_rw_en_i  in  1  core access type, 0=read 1=write
cpu_stop_i  in  1  core stop lamp
cpu_data_o  out  DATA_W  read data to core (ram_data_i passthrough)
cpu_run_o  out  1  core clock-enable / run
host_halt_i  in  1  host requests core held stopped
host_req_i  in  1  host access request, held until ack
host_we_i  in  1  host access type, 1=write
host_addr_i  in  ADDR_W  host address
host_wdata_i  in  DATA_W  host write data
host_ack_o  out  1  one-cycle access-complete pulse
host_rdata_o  out  DATA_W  registered read data, valid with ack
host_halted_o  out  1  core frozen and drained; host owns RAM
ram_addr_o  out  ADDR_W  to RAM
ram_data_o  out  DATA_W  to RAM write data
ram_rw_en_o  out  1  to RAM, 0=read 1=write
ram_data_i  in  DATA_W  from RAM; combinational read, write on rising edge when ram_rw_en_o=1

Behaviour:
- States: RUN, DRAIN, HALT, ACCESS.
- Reset (async, reset_i=0), entered immediately:
  - state=HALT, drain counter=0.
  - cpu_run_o=0, host_ack_o=0, host_rdata_o=0, host_halted_o=1.
  - ram_rw_en_o=0, ram_addr_o=0, ram_data_o=0.
- Reset mid-access aborts the access; no ack is issued.
- Boot flow: the core leaves reset frozen, so the host can load a program before the first instruction.
- RUN:
  - cpu_run_o=1; RAM pins = cpu_addr_i/cpu_data_i/cpu_rw_en_i.
  - host_halted_o=0, host_ack_o=0.
  - If host_halt_i | host_req_i | cpu_stop_i -> DRAIN, counter loaded with DRAIN_CYCLES-1.
- DRAIN:
  - cpu_run_o=0; RAM pins keep the CPU address but ram_rw_en_o is forced 0.
  - Counter decrements each cycle; at 0 -> HALT.
  - Exactly DRAIN_CYCLES cycles are spent in DRAIN.
- HALT:
  - host_halted_o=1, cpu_run_o=0; RAM pins = host_addr_i, host_wdata_i; ram_rw_en_o=0.
  - If host_req_i -> ACCESS.
  - Else if !host_halt_i & !cpu_stop_i -> RUN.
  - Else stay. A stopped core stays in HALT until reset.
- ACCESS (exactly one cycle):
  - ram_rw_en_o=host_we_i; RAM pins = host_addr_i/host_wdata_i.
  - host_rdata_o <= ram_data_i on read; unchanged on write.
  - host_ack_o=1 in the following cycle (registered). Next state HALT.
- Host handshake:
  - Host holds req/we/addr/wdata stable until ack, then drops req or presents the next request.
  - A req still high in the ack cycle is a new access.
  - Throughput: one access per 2 cycles.
- Latency:
  - req in RUN at cycle 0: DRAIN cycles 1..DRAIN_CYCLES, HALT at DRAIN_CYCLES+1, ACCESS at DRAIN_CYCLES+2, ack at DRAIN_CYCLES+3.
  - req in HALT at cycle 0: ACCESS at cycle 1, ack at cycle 2.
- Auto-resume: a req without host_halt_i halts, serves, then returns to RUN the cycle after HALT sees req=0.
- Simultaneous events:
  - stop, halt and req together in RUN -> DRAIN (single entry).
  - host_halt_i dropping in the ack cycle with req=0 -> RUN next cycle.
  - cpu_stop_i rising in DRAIN is ignored until HALT.
- Inputs in frozen states: cpu_* inputs are don't-care outside RUN; cpu_data_o is always ram_data_i.
- Width rules: no address arithmetic; addresses pass unmodified. Drain counter is 4 bits.

Decomposition:
- Package baby_mem_pkg: ADDR_W, DATA_W, RAM_WORDS=32, and the state enum {RUN, DRAIN, HALT, ACCESS}.
- One sub-module, baby_ram_port_mux: purely combinational CPU/host select of addr/data/rw with a write-block input. The FSM, counter and registered ack/rdata stay in baby_ram_arbiter.

Test Plan:
- Boot load: reset with host_halt_i=1, writes 0x0000_4001 to addr 0 and 0xFFFF_FFFF to addr 31 -> ack two cycles after each req; RAM model holds both values; cpu_run_o=0 throughout.
- Release: host_halt_i=0 with req=0 in HALT -> cpu_run_o=1 next cycle; core read of addr 31 returns 0xFFFF_FFFF on cpu_data_o.
- Halt-on-demand with DRAIN_CYCLES=2: core writing addr 5 every cycle, host read of addr 5 at cycle 0 -> cpu_run_o=0 from cycle 1; ram_rw_en_o=0 in cycles 1-2; ack at cycle 5 with rdata = last completed core write; RUN at cycle 6.
- Stop lamp: cpu_stop_i=1 in RUN -> HALT after 2 drain cycles, host_halted_o=1; core stays frozen with host_halt_i=0 until reset.
- Reset mid-access: reset_i=0 during an ACCESS write to addr 7 -> ram_rw_en_o=0 immediately, no ack; after release state=HALT, host_rdata_o=0.
- Back-to-back: req held high across 3 reads of addrs 1,2,3 -> acks at cycles 2, 4, 6 with the matching data.

Source files
------------

// File: rtl/baby_mem_pkg.sv
// Shared sizing and arbiter state type for the Baby store and its host port.
package baby_mem_pkg;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int RAM_WORDS = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALT   = 2'd2,
        ACCESS = 2'd3
    } arb_state_t;
endpackage

// File: rtl/baby_ram_port_mux.sv
// Combinational CPU/host steering of the RAM address, data and write strobe.
module baby_ram_port_mux #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              sel_host,
    input  logic              wr_block,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_rw_en,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_rw_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rw_en
);
    assign ram_addr  = sel_host ? host_addr : cpu_addr;
    assign ram_data  = sel_host ? host_data : cpu_data;
    // The block wins over both sources so a frozen core can never land a write.
    assign ram_rw_en = !wr_block && (sel_host ? host_rw_en : cpu_rw_en);
endmodule

// File: rtl/baby_ram_arbiter.sv
// Freezes and drains the Baby core so a host port can load or dump the store,
// then hands the RAM back to the core when the host lets go.
module baby_ram_arbiter #(
    parameter int ADDR_W       = baby_mem_pkg::ADDR_W,
    parameter int DATA_W       = baby_mem_pkg::DATA_W,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    input  logic              cpu_rw_en_i,
    input  logic              cpu_stop_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_run_o,
    input  logic              host_halt_i,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_ack_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_halted_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_rw_en_o,
    input  logic [DATA_W-1:0] ram_data_i
);
    import baby_mem_pkg::*;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    arb_state_t        state;
    logic [3:0]        drain_cnt;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_data;
    logic              mux_rw_en;

    always_ff @(posedge clock or negedge reset_i) begin
        if (!reset_i) begin
            state         <= HALT;
            drain_cnt     <= 4'd0;
            cpu_run_o     <= 1'b0;
            host_halted_o <= 1'b1;
            host_ack_o    <= 1'b0;
            host_rdata_o  <= '0;
        end else begin
            host_ack_o <= 1'b0;
            unique case (state)
                RUN: begin
                    if (host_halt_i || host_req_i || cpu_stop_i) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                        cpu_run_o <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        state         <= HALT;
                        host_halted_o <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                HALT: begin
                    // A lit stop lamp keeps the core parked here until reset.
                    if (host_req_i) begin
                        state <= ACCESS;
                    end else if (!host_halt_i && !cpu_stop_i) begin
                        state         <= RUN;
                        cpu_run_o     <= 1'b1;
                        host_halted_o <= 1'b0;
                    end
                end
                ACCESS: begin
                    state      <= HALT;
                    host_ack_o <= 1'b1;
                    if (!host_we_i) begin
                        host_rdata_o <= ram_data_i;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    baby_ram_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .sel_host   (state == HALT || state == ACCESS),
        .wr_block   (state == DRAIN),
        .cpu_addr   (cpu_addr_i),
        .cpu_data   (cpu_data_i),
        .cpu_rw_en  (cpu_rw_en_i),
        .host_addr  (host_addr_i),
        .host_data  (host_wdata_i),
        .host_rw_en (state == ACCESS && host_we_i),
        .ram_addr   (mux_addr),
        .ram_data   (mux_data),
        .ram_rw_en  (mux_rw_en)
    );

    // RAM pins are parked at zero for as long as reset is held.
    assign ram_addr_o  = reset_i ? mux_addr : '0;
    assign ram_data_o  = reset_i ? mux_data : '0;
    assign ram_rw_en_o = reset_i && mux_rw_en;
    assign cpu_data_o  = ram_data_i;
endmodule

// File: tb/tb_baby_ram_arbiter.sv
// Directed scenarios plus randomized traffic against a behavioural arbiter/RAM model.
module tb_baby_ram_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DC = 2;

    logic          clock = 1'b0;
    logic          reset_i = 1'b0;
    logic [AW-1:0] cpu_addr_i = '0;
    logic [DW-1:0] cpu_data_i = '0;
    logic          cpu_rw_en_i = 1'b0;
    logic          cpu_stop_i = 1'b0;
    logic [DW-1:0] cpu_data_o;
    logic          cpu_run_o;
    logic          host_halt_i = 1'b1;
    logic          host_req_i = 1'b0;
    logic          host_we_i = 1'b0;
    logic [AW-1:0] host_addr_i = '0;
    logic [DW-1:0] host_wdata_i = '0;
    logic          host_ack_o;
    logic [DW-1:0] host_rdata_o;
    logic          host_halted_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_o;
    logic          ram_rw_en_o;
    logic [DW-1:0] ram_data_i;

    always #5 clock = ~clock;

    baby_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DRAIN_CYCLES(DC)) dut (
        .clock(clock), .reset_i(reset_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_rw_en_i(cpu_rw_en_i),
        .cpu_stop_i(cpu_stop_i), .cpu_data_o(cpu_data_o), .cpu_run_o(cpu_run_o),
        .host_halt_i(host_halt_i), .host_req_i(host_req_i), .host_we_i(host_we_i),
        .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_ack_o(host_ack_o),
        .host_rdata_o(host_rdata_o), .host_halted_o(host_halted_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_rw_en_o(ram_rw_en_o),
        .ram_data_i(ram_data_i)
    );

    // Physical RAM seen by the DUT
    logic [DW-1:0] mem   [32];
    logic [DW-1:0] g_mem [32];
    assign ram_data_i = mem[ram_addr_o];
    always @(posedge clock) if (ram_rw_en_o) mem[ram_addr_o] <= ram_data_o;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the RAM, how many freeze cycles remain,
    // whether the host is being served this cycle, and the pending ack.
    bit            m_core  = 1'b0;
    int            m_left  = 0;
    bit            m_serve = 1'b0;
    bit            m_ack   = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    task automatic calc(output logic e_run, output logic e_halt, output logic e_we,
                        output logic [AW-1:0] e_a, output logic [DW-1:0] e_d);
        e_run = 1'b0; e_halt = 1'b0; e_we = 1'b0; e_a = '0; e_d = '0;
        if (!reset_i) begin
            e_halt = 1'b1;
        end else if (m_core) begin
            e_run = 1'b1; e_a = cpu_addr_i; e_d = cpu_data_i; e_we = cpu_rw_en_i;
        end else if (m_left > 0) begin
            e_a = cpu_addr_i; e_d = cpu_data_i;
        end else begin
            e_halt = 1'b1; e_a = host_addr_i; e_d = host_wdata_i;
            e_we = m_serve && host_we_i;
        end
    endtask

    logic          u_run, u_halt, u_we;
    logic [AW-1:0] u_a;
    logic [DW-1:0] u_d;
    always @(posedge clock or negedge reset_i) begin
        if (!reset_i) begin
            m_core = 1'b0; m_left = 0; m_serve = 1'b0; m_ack = 1'b0; m_rdata = '0;
        end else begin
            calc(u_run, u_halt, u_we, u_a, u_d);
            m_ack = m_serve;
            if (m_core) begin
                if (host_halt_i || host_req_i || cpu_stop_i) begin
                    m_core = 1'b0; m_left = DC;
                end
            end else if (m_left > 0) begin
                m_left--;
            end else if (m_serve) begin
                m_serve = 1'b0;
                if (!host_we_i) m_rdata = g_mem[host_addr_i];
            end else if (host_req_i) begin
                m_serve = 1'b1;
            end else if (!host_halt_i && !cpu_stop_i) begin
                m_core = 1'b1;
            end
            if (u_we) g_mem[u_a] = u_d;
        end
    end

    logic          c_run, c_halt, c_we;
    logic [AW-1:0] c_a;
    logic [DW-1:0] c_d;
    always @(negedge clock) begin
        calc(c_run, c_halt, c_we, c_a, c_d);
        chk("cpu_run", 32'(cpu_run_o), 32'(c_run));
        chk("host_halted", 32'(host_halted_o), 32'(c_halt));
        chk("ram_rw_en", 32'(ram_rw_en_o), 32'(c_we));
        chk("ram_addr", 32'(ram_addr_o), 32'(c_a));
        chk("ram_data", ram_data_o, c_d);
        chk("host_ack", 32'(host_ack_o), 32'(m_ack));
        chk("host_rdata", host_rdata_o, m_rdata);
        chk("cpu_data", cpu_data_o, g_mem[c_a]);
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic host_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               output int lat, output logic [DW-1:0] rd);
        host_req_i = 1'b1; host_we_i = we; host_addr_i = a; host_wdata_i = d;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!host_ack_o && lat < 40);
        if (!host_ack_o) begin
            total++; bad++;
            $display("FAIL ack_timeout: no ack within %0d cycles at %0t", lat, $time);
        end
        rd = host_rdata_o;
        host_req_i = 1'b0;
    endtask

    task automatic new_req();
        host_req_i   = 1'b1;
        host_we_i    = 1'($urandom_range(0, 1));
        host_addr_i  = 5'($urandom);
        host_wdata_i = $urandom;
    endtask

    initial begin
        int            lat;
        logic [DW-1:0] rd;
        int            stop_age;
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            g_mem[i] = '0;
        end

        // Reset state while reset is held
        tick();
        chk("rst_run", 32'(cpu_run_o), 32'd0);
        chk("rst_halted", 32'(host_halted_o), 32'd1);
        chk("rst_rdata", host_rdata_o, 32'd0);
        chk("rst_rw", 32'(ram_rw_en_o), 32'd0);
        tick();
        reset_i = 1'b1;

        // Boot load
        host_access(1'b1, 5'd0, 32'h0000_4001, lat, rd);
        chk("boot_lat0", 32'(lat), 32'd2);
        host_access(1'b1, 5'd31, 32'hFFFF_FFFF, lat, rd);
        chk("boot_lat31", 32'(lat), 32'd2);
        tick();
        chk("boot_mem0", mem[0], 32'h0000_4001);
        chk("boot_mem31", mem[31], 32'hFFFF_FFFF);
        chk("boot_run", 32'(cpu_run_o), 32'd0);

        // Release
        host_halt_i = 1'b0; cpu_addr_i = 5'd31; cpu_rw_en_i = 1'b0;
        tick();
        chk("rel_run", 32'(cpu_run_o), 32'd1);
        chk("rel_read31", cpu_data_o, 32'hFFFF_FFFF);

        // Halt on demand while the core writes addr 5
        cpu_addr_i = 5'd5; cpu_rw_en_i = 1'b1; cpu_data_i = 32'h0000_1234;
        tick(); tick();
        cpu_data_i = 32'hC0DE_0005;
        host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 5'd5;
        tick();
        cpu_data_i = 32'hDEAD_0001;
        chk("hod_run_c1", 32'(cpu_run_o), 32'd0);
        chk("hod_rw_c1", 32'(ram_rw_en_o), 32'd0);
        tick();
        chk("hod_rw_c2", 32'(ram_rw_en_o), 32'd0);
        tick(); tick();
        chk("hod_ack_c4", 32'(host_ack_o), 32'd0);
        tick();
        chk("hod_ack_c5", 32'(host_ack_o), 32'd1);
        chk("hod_rdata", host_rdata_o, 32'hC0DE_0005);
        host_req_i = 1'b0; cpu_rw_en_i = 1'b0;
        tick();
        chk("hod_run_c6", 32'(cpu_run_o), 32'd1);

        // Stop lamp
        cpu_stop_i = 1'b1;
        tick(); tick(); tick();
        chk("stop_halted", 32'(host_halted_o), 32'd1);
        repeat (6) tick();
        chk("stop_frozen", 32'(cpu_run_o), 32'd0);
        reset_i = 1'b0; cpu_stop_i = 1'b0; host_halt_i = 1'b1;
        tick();
        reset_i = 1'b1;
        tick();

        // Reset in the middle of a write access
        host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 5'd7; host_wdata_i = 32'h7777_7777;
        tick();
        chk("mid_rw_before", 32'(ram_rw_en_o), 32'd1);
        reset_i = 1'b0;
        #1;
        chk("mid_rw_now", 32'(ram_rw_en_o), 32'd0);
        host_req_i = 1'b0;
        tick(); tick();
        reset_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_ack", 32'(host_ack_o), 32'd0);
        end
        chk("mid_halted", 32'(host_halted_o), 32'd1);
        chk("mid_rdata", host_rdata_o, 32'd0);
        chk("mid_mem7", mem[7], 32'd0);

        // Back-to-back reads with req held high
        for (int i = 1; i <= 3; i++) host_access(1'b1, 5'(i), 32'hA000_0000 + 32'(i), lat, rd);
        tick();
        host_req_i = 1'b1; host_we_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            host_addr_i = 5'(i);
            tick();
            chk("b2b_gap", 32'(host_ack_o), 32'd0);
            tick();
            chk("b2b_ack", 32'(host_ack_o), 32'd1);
            chk("b2b_data", host_rdata_o, 32'hA000_0000 + 32'(i));
        end
        host_req_i = 1'b0;
        tick();

        // Randomized traffic
        stop_age = 0;
        for (int n = 0; n < 3000; n++) begin
            cpu_addr_i  = 5'($urandom);
            cpu_data_i  = $urandom;
            cpu_rw_en_i = 1'($urandom_range(0, 1));
            if (host_req_i) begin
                if (host_ack_o) begin
                    if ($urandom_range(0, 1) == 1) new_req();
                    else host_req_i = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                new_req();
            end
            if ($urandom_range(0, 15) == 0) host_halt_i = ~host_halt_i;
            if (cpu_stop_i) stop_age++;
            else if ($urandom_range(0, 150) == 0) cpu_stop_i = 1'b1;
            if (stop_age > 30 || $urandom_range(0, 400) == 0) begin
                reset_i = 1'b0; cpu_stop_i = 1'b0; host_req_i = 1'b0; stop_age = 0;
                tick();
                reset_i = 1'b1;
            end
            tick();
        end
        host_req_i = 1'b0;
        tick(); tick();

        for (int i = 0; i < 32; i++) chk("final_mem", mem[i], g_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
